beat_sequencer: RTL and testbench

//  Transport controller for the song/tone lookup stage. Generates beat_num and en from

---
 rtl/music_pkg.sv | 34 +++
 rtl/beat_prescaler.sv | 33 +++
 rtl/beat_sequencer.sv | 110 +++++++++++
 tb/tb_beat_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the song transport: state encoding, tempo codes and
// the beat-length divisor derived from a tempo select.
package music_pkg;

    localparam int DIV_W          = 28;
    localparam int BEAT_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] SPEED_HALF   = 2'd0;
    localparam logic [1:0] SPEED_NORMAL = 2'd1;
    localparam logic [1:0] SPEED_DOUBLE = 2'd2;
    localparam logic [1:0] SPEED_QUAD   = 2'd3;

    // Shorter divisors can truncate to zero, which would stall the beat; floor at 1.
    function automatic logic [DIV_W-1:0] div_from_speed(input logic [1:0]       speed,
                                                        input logic [DIV_W-1:0] tick_div);
        logic [DIV_W-1:0] div;
        case (speed)
            SPEED_HALF:   div = tick_div << 1;
            SPEED_NORMAL: div = tick_div;
            SPEED_DOUBLE: div = tick_div >> 1;
            default:      div = tick_div >> 2;
        endcase
        if (div == '0) div = DIV_W'(1);
        return div;
    endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Beat-length prescaler: counts clock cycles within a beat and flags the last one.
// The divisor is refreshed only on clear or at a beat boundary.
module beat_prescaler
    import music_pkg::*;
#(
    parameter logic [DIV_W-1:0] TICK_DIV = DIV_W'(12_500_000)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_q;

    assign tick = run && !clear && (count == div_q - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            div_q <= div_from_speed(SPEED_NORMAL, TICK_DIV);
        end else if (clear || tick) begin
            count <= '0;
            div_q <= div_from_speed(speed, TICK_DIV);
        end else if (run) begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Transport controller: turns play/pause/stop commands into a beat index and
// play enable for the note table. Requires SONG_LEN < 2**BEAT_W.
module beat_sequencer
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned SONG_LEN = 64,
    parameter int          BEAT_W   = BEAT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play_pulse,
    input  logic              pause_pulse,
    input  logic              stop_pulse,
    input  logic              loop_en,
    input  logic [1:0]        speed,
    output logic [BEAT_W-1:0] beat_num,
    output logic              en,
    output logic              tick,
    output logic              done_pulse,
    output logic [1:0]        state
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);
    localparam logic [BEAT_W-1:0] END_BEAT  = BEAT_W'(SONG_LEN);

    seq_state_t        cur_state, next_state;
    logic [BEAT_W-1:0] beat_next;
    logic              tick_next, done_next, en_next;
    logic              presc_run, presc_clear, presc_tick;

    // The prescaler sits at zero outside PLAY/PAUSE so a fresh start always gets a full first beat.
    assign presc_clear = stop_pulse || (cur_state == ST_IDLE) || (cur_state == ST_DONE);
    assign presc_run   = (cur_state == ST_PLAY) && !pause_pulse && !stop_pulse;

    beat_prescaler #(
        .TICK_DIV (DIV_W'(TICK_DIV))
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (presc_run),
        .clear (presc_clear),
        .speed (speed),
        .tick  (presc_tick)
    );

    always_comb begin
        next_state = cur_state;
        beat_next  = beat_num;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        if (stop_pulse) begin
            next_state = ST_IDLE;
            beat_next  = '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    beat_next = '0;
                    if (play_pulse) next_state = ST_PLAY;
                end
                ST_PLAY: begin
                    if (pause_pulse) begin
                        next_state = ST_PAUSE;
                    end else if (presc_tick) begin
                        tick_next = 1'b1;
                        if (beat_num != LAST_BEAT) begin
                            beat_next = beat_num + BEAT_W'(1);
                        end else if (loop_en) begin
                            beat_next = '0;
                        end else begin
                            beat_next  = END_BEAT;
                            next_state = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play_pulse && !pause_pulse) next_state = ST_PLAY;
                end
                ST_DONE: begin
                    if (play_pulse) begin
                        next_state = ST_PLAY;
                        beat_next  = '0;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
        en_next = (next_state == ST_PLAY) || (next_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_IDLE;
            beat_num   <= '0;
            en         <= 1'b0;
            tick       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            cur_state  <= next_state;
            beat_num   <= beat_next;
            en         <= en_next;
            tick       <= tick_next;
            done_pulse <= done_next;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed transport scenarios plus
// random command traffic, all compared cycle by cycle against a behavioural model.
module tb_beat_sequencer;

    localparam int TD = 4;
    localparam int SL = 8;
    localparam int BW = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          play_pulse = 1'b0;
    logic          pause_pulse = 1'b0;
    logic          stop_pulse = 1'b0;
    logic          loop_en = 1'b0;
    logic [1:0]    speed = 2'd1;
    logic [BW-1:0] beat_num;
    logic          en, tick, done_pulse;
    logic [1:0]    state;

    int tests_run = 0;
    int tests_failed = 0;

    int m_state, m_beat, m_elapsed, m_len, m_tick, m_done, m_en;
    int tick_seen, done_seen, en_low_seen;

    beat_sequencer #(
        .TICK_DIV (TD),
        .SONG_LEN (SL),
        .BEAT_W   (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .play_pulse  (play_pulse),
        .pause_pulse (pause_pulse),
        .stop_pulse  (stop_pulse),
        .loop_en     (loop_en),
        .speed       (speed),
        .beat_num    (beat_num),
        .en          (en),
        .tick        (tick),
        .done_pulse  (done_pulse),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic int beatLen(input int spd);
        int len;
        case (spd)
            0:       len = TD * 2;
            1:       len = TD;
            2:       len = TD / 2;
            default: len = TD / 4;
        endcase
        return (len < 1) ? 1 : len;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state = M_IDLE; m_beat = 0; m_elapsed = 0; m_len = beatLen(1);
        m_tick = 0; m_done = 0; m_en = 0;
    endtask

    // A song is a run of beats, each lasting beatLen(speed-at-its-start) cycles of PLAY.
    task automatic modelStep(input logic p, input logic pa, input logic s);
        m_tick = 0;
        m_done = 0;
        if (s) begin
            m_state = M_IDLE; m_beat = 0; m_elapsed = 0; m_len = beatLen(int'(speed));
        end else begin
            case (m_state)
                M_IDLE: begin
                    m_elapsed = 0; m_len = beatLen(int'(speed));
                    if (p) m_state = M_PLAY;
                end
                M_PLAY: begin
                    if (pa) m_state = M_PAUSE;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == m_len) begin
                            m_elapsed = 0; m_len = beatLen(int'(speed)); m_tick = 1;
                            if (m_beat == SL - 1 && !loop_en) begin
                                m_beat = SL; m_state = M_DONE; m_done = 1;
                            end else begin
                                m_beat = (m_beat + 1) % SL;
                            end
                        end
                    end
                end
                M_PAUSE: if (p && !pa) m_state = M_PLAY;
                default: begin
                    m_elapsed = 0; m_len = beatLen(int'(speed));
                    if (p) begin m_state = M_PLAY; m_beat = 0; end
                end
            endcase
        end
        m_en = (m_state == M_PLAY || m_state == M_DONE) ? 1 : 0;
    endtask

    task automatic compareAll();
        checkOutput("state", 32'(state), m_state);
        checkOutput("beat_num", 32'(beat_num), m_beat);
        checkOutput("en", 32'(en), m_en);
        checkOutput("tick", 32'(tick), m_tick);
        checkOutput("done_pulse", 32'(done_pulse), m_done);
        tick_seen   += int'(tick);
        done_seen   += int'(done_pulse);
        en_low_seen += (en === 1'b0) ? 1 : 0;
    endtask

    task automatic applyStimulus(input logic p, input logic pa, input logic s);
        @(negedge clk);
        play_pulse = p; pause_pulse = pa; stop_pulse = s;
        @(posedge clk);
        modelStep(p, pa, s);
        #1;
        compareAll();
        play_pulse = 1'b0; pause_pulse = 1'b0; stop_pulse = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearCounts();
        tick_seen = 0; done_seen = 0; en_low_seen = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_beat"}, 32'(beat_num), 0);
        checkOutput({tag, "_en"}, 32'(en), 0);
        checkOutput({tag, "_tick"}, 32'(tick), 0);
        checkOutput({tag, "_done"}, 32'(done_pulse), 0);
    endtask

    initial begin
        modelReset();
        clearCounts();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full song without looping ends in DONE with a single done strobe.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_en_after_play", 32'(en), 1);
        idleCycles(40);
        checkOutput("t1_ticks", tick_seen, 8);
        checkOutput("t1_done_count", done_seen, 1);
        checkOutput("t1_end_beat", 32'(beat_num), SL);
        checkOutput("t1_end_state", 32'(state), M_DONE);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_beat", 32'(beat_num), 0);
        checkOutput("restart_state", 32'(state), M_PLAY);

        // Looping: 20 beats wrap twice, never strobe done, never drop en.
        applyStimulus(1'b0, 1'b0, 1'b1);
        loop_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        clearCounts();
        idleCycles(80);
        checkOutput("t2_ticks", tick_seen, 20);
        checkOutput("t2_done_count", done_seen, 0);
        checkOutput("t2_en_low", en_low_seen, 0);
        checkOutput("t2_beat", 32'(beat_num), 4);

        // Pause two cycles into beat 3, resume, finish the partial beat.
        applyStimulus(1'b0, 1'b0, 1'b1);
        loop_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearCounts();
        idleCycles(10);
        checkOutput("t3_en_low_paused", en_low_seen, 10);
        checkOutput("t3_beat_frozen", 32'(beat_num), 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t3_no_early_tick", 32'(tick), 0);
        idleCycles(1);
        checkOutput("t3_resume_tick", 32'(tick), 1);
        checkOutput("t3_resume_beat", 32'(beat_num), 4);

        // Coinciding commands.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_stop_wins_state", 32'(state), M_IDLE);
        checkOutput("t4_stop_wins_beat", 32'(beat_num), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_play_from_idle", 32'(state), M_PLAY);

        // Tempo changes apply only at beat boundaries.
        loop_en = 1'b1;
        idleCycles(2);
        speed = 2'd3;
        clearCounts();
        idleCycles(1);
        checkOutput("t5_old_beat_holds", tick_seen, 0);
        idleCycles(1);
        checkOutput("t5_old_beat_ends", tick_seen, 1);
        idleCycles(4);
        checkOutput("t5_fast_beats", tick_seen, 5);
        speed = 2'd0;
        clearCounts();
        idleCycles(1);
        idleCycles(7);
        checkOutput("t5_slow_beat_holds", tick_seen, 1);
        idleCycles(1);
        checkOutput("t5_slow_beat_ends", tick_seen, 2);
        speed = 2'd1;

        // Asynchronous reset in the middle of beat 5.
        applyStimulus(1'b0, 1'b0, 1'b1);
        loop_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(22);
        checkOutput("t6_pre_reset_beat", 32'(beat_num), 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("t6_async");
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random command traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic p, pa, s;
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            p  = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 15) == 0);
            s  = ($urandom_range(0, 39) == 0);
            applyStimulus(p, pa, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
